// File: rtl/uu_tracker_pkg.sv
// Shared types and default widths for the multi-cycle unit rd tracker.
// Slot state encodings and the per-slot record live here.
package uu_tracker_pkg;

  localparam int UU_NUM_RDS = 9;
  localparam int UU_RD_W    = 5;
  localparam int UU_INT_RDS = 2;
  localparam int UU_WDOG_W  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    KILLED = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e          state;
    logic [UU_RD_W-1:0]   rd;
    logic                 reg_write;
    logic                 fp_reg_write;
    logic [UU_WDOG_W-1:0] wdog;
  } slot_t;

endpackage

// File: rtl/uu_slot.sv
// One tracked unit slot: ownership FSM, rd/type latches, watchdog.
// Events are combinational; the top registers the falling pulses.
module uu_slot
  import uu_tracker_pkg::*;
#(
  parameter bit INT_ONLY = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               issue_i,
  input  logic [UU_RD_W-1:0] rd_i,
  input  logic               reg_write_i,
  input  logic               fp_reg_write_i,
  input  logic               done_i,
  input  logic               clear_i,
  output logic [UU_RD_W-1:0] rd_o,
  output logic               busy_o,
  output logic               reg_write_o,
  output logic               fp_reg_write_o,
  output logic               wb_en_o,
  output logic               conflict_o,
  output logic               fall_o,
  output logic               fall_int_o,
  output logic               hang_o
);

  slot_t s_q, s_d;
  logic  hang_q, hang_d;
  logic  load;
  logic  active;

  assign active = (s_q.state != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s_q    <= '0;
      hang_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      hang_q <= hang_d;
    end
  end

  always_comb begin
    s_d  = s_q;
    load = 1'b0;
    unique case (s_q.state)
      IDLE: begin
        if (issue_i) load = 1'b1;
      end
      BUSY: begin
        if (done_i && issue_i) load = 1'b1;
        else if (done_i)       s_d.state = IDLE;
        else if (clear_i)      s_d.state = KILLED;
      end
      KILLED: begin
        if (done_i && issue_i) load = 1'b1;
        else if (done_i)       s_d.state = IDLE;
      end
      default: s_d.state = IDLE;
    endcase

    if (load) begin
      s_d.state        = BUSY;
      s_d.rd           = rd_i;
      s_d.reg_write    = reg_write_i;
      s_d.fp_reg_write = fp_reg_write_i & ~INT_ONLY;
      s_d.wdog         = '0;
    end else if (s_d.state == IDLE) begin
      s_d.wdog = '0;
    end else if (s_q.wdog != '1) begin
      s_d.wdog = s_q.wdog + 1'b1;
    end

    // hang is sticky; only reset clears it
    hang_d = hang_q | (s_d.wdog == '1);
  end

  assign rd_o           = s_q.rd;
  assign busy_o         = active;
  assign reg_write_o    = s_q.reg_write;
  assign fp_reg_write_o = s_q.fp_reg_write;
  assign hang_o         = hang_q;

  assign wb_en_o    = done_i & (s_q.state == BUSY) & ~clear_i;
  assign conflict_o = issue_i & active & ~done_i;
  assign fall_o     = active & done_i & ~issue_i;
  assign fall_int_o = fall_o & s_q.reg_write & ~s_q.fp_reg_write
                    & ~INT_ONLY;

endmodule

// File: rtl/uu_rd_tracker.sv
// Destination-register ownership tracker for multi-cycle units.
// Feeds the WAW clear decoder and the hazard unit.
module uu_rd_tracker
  import uu_tracker_pkg::*;
#(
  parameter int NUM_RDS       = UU_NUM_RDS,
  parameter int RD_ADDR_WIDTH = UU_RD_W,
  parameter int INT_UU_RDS    = UU_INT_RDS,
  parameter int WDOG_WIDTH    = UU_WDOG_W
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  issue_valid_i,
  input  logic [NUM_RDS-1:0]                    issue_unit_i,
  input  logic [RD_ADDR_WIDTH-1:0]              issue_rd_i,
  input  logic                                  issue_reg_write_i,
  input  logic                                  issue_fp_reg_write_i,
  input  logic [NUM_RDS-1:0]                    unit_done_i,
  input  logic [NUM_RDS-1:0]                    clear_rd_i,
  output logic [NUM_RDS-1:0][RD_ADDR_WIDTH-1:0] rd_used_o,
  output logic [NUM_RDS-1:0]                    rd_busy_o,
  output logic [NUM_RDS-1:0]                    reg_write_unit_o,
  output logic [NUM_RDS-1:0]                    fp_reg_write_unit_o,
  output logic [NUM_RDS-1:0]                    wb_en_o,
  output logic                                  rd_busy_falling_o,
  output logic                                  fp_rd_is_int_falling_o,
  output logic [NUM_RDS-1:0]                    hang_o,
  output logic                                  issue_conflict_o
);

  // slot_t is sized from the package widths
  if (RD_ADDR_WIDTH != UU_RD_W || WDOG_WIDTH != UU_WDOG_W) begin : g_bad_w
    $error("uu_rd_tracker: widths must match uu_tracker_pkg");
  end

  logic [NUM_RDS-1:0] conflict;
  logic [NUM_RDS-1:0] fall;
  logic [NUM_RDS-1:0] fall_int;
  logic               fall_q, fall_d;
  logic               fall_int_q, fall_int_d;

  for (genvar i = 0; i < NUM_RDS; i++) begin : g_slot
    uu_slot #(
      .INT_ONLY (i < INT_UU_RDS)
    ) u_slot (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .issue_i        (issue_valid_i & issue_unit_i[i]),
      .rd_i           (issue_rd_i),
      .reg_write_i    (issue_reg_write_i),
      .fp_reg_write_i (issue_fp_reg_write_i),
      .done_i         (unit_done_i[i]),
      .clear_i        (clear_rd_i[i]),
      .rd_o           (rd_used_o[i]),
      .busy_o         (rd_busy_o[i]),
      .reg_write_o    (reg_write_unit_o[i]),
      .fp_reg_write_o (fp_reg_write_unit_o[i]),
      .wb_en_o        (wb_en_o[i]),
      .conflict_o     (conflict[i]),
      .fall_o         (fall[i]),
      .fall_int_o     (fall_int[i]),
      .hang_o         (hang_o[i])
    );
  end

  assign fall_d     = |fall;
  assign fall_int_d = |fall_int;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fall_q     <= 1'b0;
      fall_int_q <= 1'b0;
    end else begin
      fall_q     <= fall_d;
      fall_int_q <= fall_int_d;
    end
  end

  assign rd_busy_falling_o      = fall_q;
  assign fp_rd_is_int_falling_o = fall_int_q;
  assign issue_conflict_o       = |conflict;

endmodule

// File: tb/tb_uu_rd_tracker.sv
// Directed-vector bench for uu_rd_tracker.
// Each task drives one scenario and checks hand-computed values.
module tb_uu_rd_tracker;

  logic           clk = 1'b0;
  logic           reset;
  logic           issue_valid;
  logic [8:0]     issue_unit;
  logic [4:0]     issue_rd;
  logic           issue_reg_write;
  logic           issue_fp_reg_write;
  logic [8:0]     unit_done;
  logic [8:0]     clear_rd;
  logic [8:0][4:0] rd_used;
  logic [8:0]     rd_busy;
  logic [8:0]     reg_write_unit;
  logic [8:0]     fp_reg_write_unit;
  logic [8:0]     wb_en;
  logic           rd_busy_falling;
  logic           fp_rd_is_int_falling;
  logic [8:0]     hang;
  logic           issue_conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uu_rd_tracker dut (
    .clk_i                  (clk),
    .reset_i                (reset),
    .issue_valid_i          (issue_valid),
    .issue_unit_i           (issue_unit),
    .issue_rd_i             (issue_rd),
    .issue_reg_write_i      (issue_reg_write),
    .issue_fp_reg_write_i   (issue_fp_reg_write),
    .unit_done_i            (unit_done),
    .clear_rd_i             (clear_rd),
    .rd_used_o              (rd_used),
    .rd_busy_o              (rd_busy),
    .reg_write_unit_o       (reg_write_unit),
    .fp_reg_write_unit_o    (fp_reg_write_unit),
    .wb_en_o                (wb_en),
    .rd_busy_falling_o      (rd_busy_falling),
    .fp_rd_is_int_falling_o (fp_rd_is_int_falling),
    .hang_o                 (hang),
    .issue_conflict_o       (issue_conflict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid        = 1'b0;
    issue_unit         = '0;
    issue_rd           = '0;
    issue_reg_write    = 1'b0;
    issue_fp_reg_write = 1'b0;
    unit_done          = '0;
    clear_rd           = '0;
  endtask

  task automatic issue(input int u, input logic [4:0] rd,
                       input logic iw, input logic fw);
    issue_valid        = 1'b1;
    issue_unit         = 9'd1 << u;
    issue_rd           = rd;
    issue_reg_write    = iw;
    issue_fp_reg_write = fw;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (rd_busy !== 9'd0) begin
      errors++;
      $display("FAIL reset_busy got=%h exp=000", rd_busy);
    end
    checks++;
    if (rd_used !== 45'd0) begin
      errors++;
      $display("FAIL reset_rd got=%h exp=0", rd_used);
    end
    checks++;
    if ({hang, rd_busy_falling, fp_rd_is_int_falling} !== 11'd0) begin
      errors++;
      $display("FAIL reset_flags got=%h exp=0",
               {hang, rd_busy_falling, fp_rd_is_int_falling});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    issue(0, 5'd5, 1'b1, 1'b1);
    tick();
    idle_in();
    checks++;
    if (rd_busy[0] !== 1'b1 || rd_used[0] !== 5'd5) begin
      errors++;
      $display("FAIL basic_issue busy=%b rd=%0d exp busy=1 rd=5",
               rd_busy[0], rd_used[0]);
    end
    checks++;
    if (reg_write_unit[0] !== 1'b1 || fp_reg_write_unit[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags iw=%b fw=%b exp iw=1 fw=0",
               reg_write_unit[0], fp_reg_write_unit[0]);
    end
    tick();
    tick();
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold busy=%b exp=1", rd_busy[0]);
    end
    unit_done[0] = 1'b1;
    #1;
    checks++;
    if (wb_en !== 9'h001) begin
      errors++;
      $display("FAIL basic_wb got=%h exp=001", wb_en);
    end
    tick();
    idle_in();
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_busy_falling !== 1'b1
        || fp_rd_is_int_falling !== 1'b0) begin
      errors++;
      $display("FAIL basic_fall busy=%b fall=%b fi=%b exp 0 1 0",
               rd_busy[0], rd_busy_falling, fp_rd_is_int_falling);
    end
    tick();
    checks++;
    if (rd_busy_falling !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse fall=%b exp=0", rd_busy_falling);
    end
  endtask

  task automatic test_killed();
    issue(4, 5'd7, 1'b0, 1'b1);
    tick();
    idle_in();
    checks++;
    if (fp_reg_write_unit[4] !== 1'b1 || reg_write_unit[4] !== 1'b0) begin
      errors++;
      $display("FAIL kill_flags fw=%b iw=%b exp fw=1 iw=0",
               fp_reg_write_unit[4], reg_write_unit[4]);
    end
    tick();
    clear_rd[4] = 1'b1;
    tick();
    clear_rd[4] = 1'b0;
    checks++;
    if (dut.g_slot[4].u_slot.s_q.state !== 2'd2 || rd_busy[4] !== 1'b1) begin
      errors++;
      $display("FAIL kill_state st=%0d busy=%b exp st=2 busy=1",
               dut.g_slot[4].u_slot.s_q.state, rd_busy[4]);
    end
    tick();
    clear_rd[4] = 1'b1;
    tick();
    clear_rd[4]  = 1'b0;
    unit_done[4] = 1'b1;
    #1;
    checks++;
    if (wb_en[4] !== 1'b0 || rd_used[4] !== 5'd7) begin
      errors++;
      $display("FAIL kill_wb wb=%b rd=%0d exp wb=0 rd=7",
               wb_en[4], rd_used[4]);
    end
    tick();
    idle_in();
    checks++;
    if (rd_busy[4] !== 1'b0 || rd_busy_falling !== 1'b1
        || fp_rd_is_int_falling !== 1'b0) begin
      errors++;
      $display("FAIL kill_fall busy=%b fall=%b fi=%b exp 0 1 0",
               rd_busy[4], rd_busy_falling, fp_rd_is_int_falling);
    end
    tick();
  endtask

  task automatic test_clear_and_done();
    issue(3, 5'd3, 1'b1, 1'b0);
    tick();
    idle_in();
    clear_rd[3]  = 1'b1;
    unit_done[3] = 1'b1;
    #1;
    checks++;
    if (wb_en[3] !== 1'b0) begin
      errors++;
      $display("FAIL clrdone_wb got=%b exp=0", wb_en[3]);
    end
    tick();
    idle_in();
    checks++;
    if (rd_busy[3] !== 1'b0 || fp_rd_is_int_falling !== 1'b1) begin
      errors++;
      $display("FAIL clrdone_fall busy=%b fi=%b exp busy=0 fi=1",
               rd_busy[3], fp_rd_is_int_falling);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(2, 5'd9, 1'b1, 1'b0);
    tick();
    issue(2, 5'd12, 1'b1, 1'b0);
    unit_done[2] = 1'b1;
    #1;
    checks++;
    if (wb_en[2] !== 1'b1 || issue_conflict !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wb wb=%b conf=%b exp wb=1 conf=0",
               wb_en[2], issue_conflict);
    end
    tick();
    idle_in();
    checks++;
    if (rd_used[2] !== 5'd12 || rd_busy[2] !== 1'b1
        || rd_busy_falling !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload rd=%0d busy=%b fall=%b exp 12 1 0",
               rd_used[2], rd_busy[2], rd_busy_falling);
    end
    unit_done[2] = 1'b1;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_conflict();
    issue(1, 5'd4, 1'b1, 1'b1);
    tick();
    checks++;
    if (fp_reg_write_unit[1] !== 1'b0) begin
      errors++;
      $display("FAIL intonly_fw got=%b exp=0", fp_reg_write_unit[1]);
    end
    issue(1, 5'd20, 1'b1, 1'b0);
    #1;
    checks++;
    if (issue_conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict got=%b exp=1", issue_conflict);
    end
    tick();
    idle_in();
    checks++;
    if (rd_used[1] !== 5'd4 || rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL conflict_keep rd=%0d busy=%b exp rd=4 busy=1",
               rd_used[1], rd_busy[1]);
    end
    unit_done[1] = 1'b1;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_x0();
    issue(7, 5'd0, 1'b1, 1'b0);
    tick();
    idle_in();
    unit_done[7] = 1'b1;
    #1;
    checks++;
    if (wb_en !== 9'h080) begin
      errors++;
      $display("FAIL x0_wb got=%h exp=080", wb_en);
    end
    tick();
    idle_in();
    checks++;
    if (fp_rd_is_int_falling !== 1'b1 || rd_busy_falling !== 1'b1) begin
      errors++;
      $display("FAIL x0_fall fi=%b fall=%b exp 1 1",
               fp_rd_is_int_falling, rd_busy_falling);
    end
    tick();
  endtask

  task automatic test_watchdog();
    issue(6, 5'd11, 1'b1, 1'b0);
    tick();
    idle_in();
    repeat (62) tick();
    checks++;
    if (hang[6] !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early got=%b exp=0", hang[6]);
    end
    tick();
    checks++;
    if (hang !== 9'h040) begin
      errors++;
      $display("FAIL wdog_hang got=%h exp=040", hang);
    end
    unit_done[6] = 1'b1;
    tick();
    idle_in();
    tick();
    checks++;
    if (hang[6] !== 1'b1 || rd_busy[6] !== 1'b0) begin
      errors++;
      $display("FAIL wdog_sticky hang=%b busy=%b exp 1 0",
               hang[6], rd_busy[6]);
    end
  endtask

  task automatic test_async_reset();
    issue(0, 5'd3, 1'b1, 1'b0);
    tick();
    issue(5, 5'd17, 1'b0, 1'b1);
    tick();
    idle_in();
    checks++;
    if (rd_busy !== 9'h021) begin
      errors++;
      $display("FAIL arst_pre got=%h exp=021", rd_busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rd_busy !== 9'd0 || rd_used !== 45'd0 || hang !== 9'd0) begin
      errors++;
      $display("FAIL arst_now busy=%h rd=%h hang=%h exp 0 0 0",
               rd_busy, rd_used, hang);
    end
    tick();
    reset = 1'b0;
    unit_done = 9'h021;
    #1;
    checks++;
    if (wb_en !== 9'd0) begin
      errors++;
      $display("FAIL arst_wb got=%h exp=000", wb_en);
    end
    tick();
    idle_in();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_killed();
    test_clear_and_done();
    test_back_to_back();
    test_conflict();
    test_x0();
    test_watchdog();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uu_rd_tracker.md
Name: uu_rd_tracker

Overview:
- Tracks destination-register ownership for every multi-cycle execution unit (int mul/div, FP units, FPU).
- Latches rd and register type on issue, then holds each unit's slot busy until the unit reports completion.
- Receives per-unit clear_rd from the WAW clear decoder. A cleared slot stays busy, but its writeback is suppressed.
- Drives the rd_used, busy, reg-type and falling-edge signals that the clear decoder and the hazard unit consume.

Parameters:
- NUM_RDS, 9, number of tracked unit slots.
- RD_ADDR_WIDTH, 5, rd address bits.
- INT_UU_RDS, 2, slots [0..INT_UU_RDS-1] are integer-only units.
- WDOG_WIDTH, 6, watchdog counter bits; hang flagged when a slot's count saturates.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction enters a unit this cycle
- issue_unit  in  NUM_RDS  one-hot target slot
- issue_rd  in  RD_ADDR_WIDTH  destination register
- issue_reg_write  in  1  writes the integer regfile
- issue_fp_reg_write  in  1  writes the FP regfile
- unit_done  in  NUM_RDS  per-unit result valid (1-cycle pulse)
- clear_rd  in  NUM_RDS  per-unit WAW clear from the decoder
- rd_used  out  NUM_RDS x RD_ADDR_WIDTH  latched rd per slot
- rd_busy  out  NUM_RDS  slot occupied (BUSY or KILLED)
- reg_write_unit  out  NUM_RDS  latched integer-write flag
- fp_reg_write_unit  out  NUM_RDS  latched FP-write flag
- wb_en  out  NUM_RDS  combinational; done AND slot BUSY AND no clear this cycle
- rd_busy_falling  out  1  registered pulse, one cycle after any slot returns to IDLE
- fp_rd_is_int_falling  out  1  registered pulse; the slot that freed had reg_write=1 and fp_reg_write=0 and is index >= INT_UU_RDS
- hang  out  NUM_RDS  sticky watchdog flag per slot
- issue_conflict  out  1  combinational; issue to a slot that is busy and not done this cycle

Behaviour:
- Reset: all slots IDLE. rd_used=0, rd_busy=0, reg_write_unit=0, fp_reg_write_unit=0, rd_busy_falling=0, fp_rd_is_int_falling=0, hang=0, watchdogs=0. Reset mid-operation discards all slots immediately.
- Per-slot FSM, states IDLE, BUSY, KILLED:
  - IDLE + issue to this slot -> BUSY. rd and both type flags latch on the same edge, watchdog clears.
  - BUSY + clear_rd -> KILLED; rd and flags are retained.
  - BUSY + unit_done -> IDLE, with wb_en high in that cycle.
  - BUSY + unit_done + clear_rd in the same cycle -> IDLE, with wb_en low (clear wins).
  - KILLED + unit_done -> IDLE, with wb_en low. clear_rd in KILLED is ignored.
  - Any state + unit_done + issue to the same slot -> BUSY with the new rd (back-to-back reload). No falling pulse is generated for that slot.
- Issue to a slot that is BUSY/KILLED without a same-cycle done: the issue is ignored, slot state is unchanged and issue_conflict=1.
- clear_rd and unit_done in IDLE are ignored.
- Issue with issue_rd=0 and issue_reg_write=1 (integer write): slot still goes BUSY, wb_en still asserts (the regfile drops x0 writes).
- Integer-only slots (index < INT_UU_RDS) latch fp_reg_write_unit as 0 regardless of input.
- Watchdog: increments each cycle the slot is not IDLE and saturates at all-ones. Saturation sets hang[i], which stays set until reset. Returning to IDLE clears the counter but not hang.
- rd_busy_falling / fp_rd_is_int_falling: assert one cycle after the edge on which a slot goes BUSY/KILLED -> IDLE, without a reload. Several slots freeing at once give a single pulse.
- Latency: outputs other than wb_en and issue_conflict change only on the clk edge.

Decomposition:
- Package uu_tracker_pkg holds:
  - typedef enum slot_state_e {IDLE, BUSY, KILLED} (2 bits)
  - typedef struct slot_t {state, rd, reg_write, fp_reg_write, wdog}
  - constants for default widths
- One sub-module, uu_slot, covers a single slot's FSM, latches and watchdog.
- The top level generates NUM_RDS instances and ORs their falling events into the registered pulses.

Test Plan:
- Issue slot 0, rd=5, int write; unit_done 3 cycles later -> rd_busy[0]=1 for 3 cycles, wb_en[0]=1 in the done cycle, rd_busy_falling=1 one cycle later.
- Issue slot 4, rd=7, FP write; clear_rd[4] at cycle 2; done at cycle 5 -> state KILLED from cycle 3, wb_en[4]=0 at cycle 5, rd_busy[4]=0 at cycle 6.
- Slot 3 BUSY; clear_rd[3] and unit_done[3] in the same cycle -> wb_en[3]=0, slot IDLE next cycle.
- Slot 2 BUSY with rd=9; unit_done[2] plus issue to slot 2 with rd=12 -> wb_en[2]=1, rd_used[2]=12, rd_busy stays 1, no falling pulse.
- Issue to busy slot 1 without done -> issue_conflict=1, rd_used[1] unchanged. Hold slot 6 busy for 63 cycles -> hang[6]=1 and sticky.
- Assert reset while slots 0 and 5 are busy -> all outputs 0 immediately (asynchronous); a later unit_done gives no wb_en.
